pic_ctrl: RTL and testbench

PIC_CTRL -- requirements
Module: pic_ctrl

---
 rtl/pic_pkg.sv | 10 +
 rtl/pic_prio_enc.sv | 15 +
 rtl/pic_ctrl.sv | 101 ++++++++++
 tb/tb_pic_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: shared constants for the pic_ctrl interrupt controller register map.
package pic_pkg;
    localparam int NSRC_MAX = 16;
    localparam logic [4:0] OFF_PENDING = 5'h00;
    localparam logic [4:0] OFF_MASK    = 5'h04;
    localparam logic [4:0] OFF_MODE    = 5'h08;
    localparam logic [4:0] OFF_FORCE   = 5'h0C;
    localparam logic [4:0] OFF_ACTIVE  = 5'h10;
    localparam logic [NSRC_MAX-1:0] MODE_RST = {NSRC_MAX{1'b1}};
endpackage

// File: rtl/pic_prio_enc.sv
// pic_prio_enc: 16-bit priority encoder, lowest index wins, id=0 when idle.
module pic_prio_enc
    import pic_pkg::*;
(
    input  logic [NSRC_MAX-1:0] vec,
    output logic [3:0]          id,
    output logic                any
);
    always_comb begin
        id = 4'd0;
        for (int i = NSRC_MAX - 1; i >= 0; i--)
            if (vec[i]) id = 4'(i);
    end
    assign any = |vec;
endmodule

// File: rtl/pic_ctrl.sv
// pic_ctrl: memory-mapped interrupt controller with edge/level sources and priority id.
// Define PIC_SYNC_EN to insert a two-flop synchronizer on irq_src.
module pic_ctrl
    import pic_pkg::*;
#(
    parameter int          NSRC = 16,
    parameter logic [17:0] BASE = 18'h3F000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic [NSRC-1:0] irq_src,
    input  logic [17:0]     mem_addr,
    input  logic            mem_re,
    input  logic [3:0]      mem_we,
    input  logic [31:0]     mem_wdata,
    output logic [31:0]     mem_rdata,
    output logic            sel,
    output logic [15:0]     interrupts,
    output logic            irq_any,
    output logic [3:0]      irq_id
);
    logic [NSRC-1:0] pend_q, pend_d, mask_q, mask_d, mode_q, mode_d;
    logic [NSRC-1:0] hist_q, hist_d, int_q, int_d, smp, edg, w1c, frc, wd;
    logic [31:0]     rdata_q, rdata_d, rd_val;
    logic [1:0]      init_q, init_d;
    logic [4:0]      off;
    logic            wr;
    logic            unused_wdata;

`ifdef PIC_SYNC_EN
    localparam logic [1:0] INIT_CNT = 2'd3;
    logic [NSRC-1:0] s1_q, s2_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= irq_src;
            s2_q <= s1_q;
        end
    end
    assign smp = s2_q;
`else
    localparam logic [1:0] INIT_CNT = 2'd1;
    assign smp = irq_src;
`endif

    assign sel          = mem_addr[17:5] == BASE[17:5];
    assign off          = mem_addr[4:0];
    assign wd           = mem_wdata[NSRC-1:0];
    assign unused_wdata = ^mem_wdata[31:NSRC];

    // init_q masks edges until history has seen the post-reset level of every source
    always_comb begin
        wr     = clk_en & sel & (mem_we == 4'hF);
        w1c    = (wr && off == OFF_PENDING) ? wd : '0;
        frc    = (wr && off == OFF_FORCE) ? wd : '0;
        edg    = (init_q == 2'd0) ? smp & ~hist_q : '0;
        mask_d = (wr && off == OFF_MASK) ? wd : mask_q;
        mode_d = (wr && off == OFF_MODE) ? wd : mode_q;
        pend_d = (mode_q & ((pend_q & ~w1c) | frc | edg)) | (~mode_q & smp);
        hist_d = smp;
        init_d = (init_q == 2'd0) ? 2'd0 : init_q - 2'd1;
        int_d  = pend_d & mask_d;
        rd_val = off == OFF_PENDING ? 32'(pend_q) :
                 off == OFF_MASK    ? 32'(mask_q) :
                 off == OFF_MODE    ? 32'(mode_q) :
                 off == OFF_ACTIVE  ? 32'(int_q)  : 32'd0;
        rdata_d = (clk_en & mem_re & sel) ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= '0;
            mask_q  <= '0;
            mode_q  <= MODE_RST[NSRC-1:0];
            hist_q  <= '0;
            int_q   <= '0;
            rdata_q <= '0;
            init_q  <= INIT_CNT;
        end else begin
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            hist_q  <= hist_d;
            int_q   <= int_d;
            rdata_q <= rdata_d;
            init_q  <= init_d;
        end
    end

    assign mem_rdata  = rdata_q;
    assign interrupts = 16'(int_q);

    pic_prio_enc u_prio (
        .vec (interrupts),
        .id  (irq_id),
        .any (irq_any)
    );
endmodule

// File: tb/tb_pic_ctrl.sv
// tb_pic_ctrl: directed self-checking bench for pic_ctrl (honours PIC_SYNC_EN latency).
module tb_pic_ctrl;
    import pic_pkg::*;
    localparam logic [17:0] BASE = 18'h3F000;
`ifdef PIC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 0, rst = 1, clk_en = 1, mem_re = 0, sel, irq_any;
    logic [15:0] irq_src = 0, interrupts;
    logic [17:0] mem_addr = 0;
    logic [3:0]  mem_we = 0, irq_id;
    logic [31:0] mem_wdata = 0, mem_rdata;
    int n_cmp = 0, n_bad = 0;

    pic_ctrl #(.NSRC(16), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .irq_src(irq_src),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .sel(sel), .interrupts(interrupts),
        .irq_any(irq_any), .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [4:0] off, input logic [31:0] d);
        mem_addr  = BASE + 18'(off);
        mem_wdata = d;
        mem_we    = 4'hF;
        tick();
        mem_we    = 4'h0;
    endtask

    task automatic rd_reg(input logic [4:0] off, output logic [31:0] d);
        mem_addr = BASE + 18'(off);
        mem_re   = 1;
        tick();
        d        = mem_rdata;
        mem_re   = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (interrupts !== 16'h0 || irq_any !== 1'b0 || irq_id !== 4'd0 || mem_rdata !== 32'h0) begin
            $display("FAIL reset_out int=%h any=%b id=%0d rdata=%h want all 0", interrupts, irq_any, irq_id, mem_rdata); n_bad++; end
        rst = 0;
        repeat (4) tick();
        rd_reg(OFF_MODE, d);
        n_cmp++; if (d !== 32'h0000FFFF) begin $display("FAIL reset_mode got %h want 0000ffff", d); n_bad++; end
        rd_reg(OFF_MASK, d);
        n_cmp++; if (d !== 32'h0) begin $display("FAIL reset_mask got %h want 0", d); n_bad++; end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        mem_addr = BASE;
        #1 n_cmp++; if (sel !== 1'b1) begin $display("FAIL sel_base got %b want 1", sel); n_bad++; end
        mem_addr = BASE + 18'h1F;
        #1 n_cmp++; if (sel !== 1'b1) begin $display("FAIL sel_top got %b want 1", sel); n_bad++; end
        mem_addr = BASE + 18'h20;
        #1 n_cmp++; if (sel !== 1'b0) begin $display("FAIL sel_above got %b want 0", sel); n_bad++; end
        mem_addr = BASE - 18'h1;
        #1 n_cmp++; if (sel !== 1'b0) begin $display("FAIL sel_below got %b want 0", sel); n_bad++; end
        wr_reg(OFF_MASK, 32'h1234);
        mem_addr = BASE + 18'(OFF_MASK); mem_wdata = 32'hFFFF; mem_we = 4'h7;
        tick(); mem_we = 0;
        rd_reg(OFF_MASK, d);
        n_cmp++; if (d !== 32'h1234) begin $display("FAIL partial_wr got %h want 00001234", d); n_bad++; end
        wr_reg(5'h14, 32'hFFFF_FFFF);
        rd_reg(5'h14, d);
        n_cmp++; if (d !== 32'h0) begin $display("FAIL unmapped got %h want 0", d); n_bad++; end
        rd_reg(OFF_FORCE, d);
        n_cmp++; if (d !== 32'h0) begin $display("FAIL force_rd got %h want 0", d); n_bad++; end
        wr_reg(OFF_MASK, 32'h0);
    endtask

    task automatic test_edge();
        logic [31:0] d;
        wr_reg(OFF_MASK, 32'h0008);
        irq_src = 16'h0008; tick(); irq_src = 0;
        for (int k = 1; k < LAT; k++) begin
            n_cmp++; if (interrupts !== 16'h0) begin $display("FAIL edge_early k=%0d got %h want 0000", k, interrupts); n_bad++; end
            tick();
        end
        n_cmp++; if (interrupts !== 16'h0008 || irq_id !== 4'd3 || irq_any !== 1'b1) begin
            $display("FAIL edge_set int=%h id=%0d any=%b want 0008/3/1", interrupts, irq_id, irq_any); n_bad++; end
        repeat (4) tick();
        rd_reg(OFF_PENDING, d);
        n_cmp++; if (interrupts !== 16'h0008 || d !== 32'h8) begin $display("FAIL edge_hold int=%h pend=%h want 0008/8", interrupts, d); n_bad++; end
        wr_reg(OFF_PENDING, 32'h0008);
        n_cmp++; if (interrupts !== 16'h0 || irq_any !== 1'b0) begin $display("FAIL edge_w1c int=%h any=%b want 0000/0", interrupts, irq_any); n_bad++; end
    endtask

    task automatic test_edge_vs_w1c();
        logic [31:0] d;
        wr_reg(OFF_MASK, 32'h0020);
        irq_src = 16'h0020; tick(); irq_src = 0;
        repeat (LAT + 1) tick();
        irq_src = 16'h0020;
        repeat (LAT - 1) tick();
        wr_reg(OFF_PENDING, 32'h0020);
        rd_reg(OFF_PENDING, d);
        n_cmp++; if (d !== 32'h20 || interrupts !== 16'h0020) begin $display("FAIL edge_beats_w1c pend=%h int=%h want 20/0020", d, interrupts); n_bad++; end
        irq_src = 0;
        wr_reg(OFF_PENDING, 32'h0020);
        n_cmp++; if (interrupts !== 16'h0) begin $display("FAIL w1c_alone got %h want 0000", interrupts); n_bad++; end
        repeat (LAT + 1) tick();
    endtask

    task automatic test_level();
        wr_reg(OFF_MODE, 32'h0);
        wr_reg(OFF_MASK, 32'hFFFF);
        irq_src = 16'h0101; repeat (LAT) tick();
        n_cmp++; if (interrupts !== 16'h0101 || irq_id !== 4'd0) begin $display("FAIL level_a int=%h id=%0d want 0101/0", interrupts, irq_id); n_bad++; end
        irq_src = 16'h0100; repeat (LAT) tick();
        n_cmp++; if (interrupts !== 16'h0100 || irq_id !== 4'd8) begin $display("FAIL level_b int=%h id=%0d want 0100/8", interrupts, irq_id); n_bad++; end
        wr_reg(OFF_PENDING, 32'hFFFF);
        wr_reg(OFF_FORCE, 32'h0001);
        tick();
        n_cmp++; if (interrupts !== 16'h0100) begin $display("FAIL level_w1c_force got %h want 0100", interrupts); n_bad++; end
        irq_src = 0; repeat (LAT) tick();
        n_cmp++; if (interrupts !== 16'h0) begin $display("FAIL level_drop got %h want 0000", interrupts); n_bad++; end
        wr_reg(OFF_MODE, 32'hFFFF);
        wr_reg(OFF_MASK, 32'h0);
    endtask

    task automatic test_clk_en();
        logic [31:0] d;
        wr_reg(OFF_MASK, 32'h8000);
        rd_reg(OFF_MODE, d);
        mem_addr = BASE + 18'(OFF_FORCE); mem_wdata = 32'h8000; mem_we = 4'hF;
        clk_en = 0; repeat (3) tick();
        n_cmp++; if (interrupts !== 16'h0) begin $display("FAIL force_gated got %h want 0000", interrupts); n_bad++; end
        clk_en = 1; tick(); mem_we = 0;
        n_cmp++; if (interrupts !== 16'h8000 || irq_id !== 4'd15) begin $display("FAIL force_set int=%h id=%0d want 8000/15", interrupts, irq_id); n_bad++; end
        mem_addr = BASE + 18'(OFF_ACTIVE); mem_re = 1;
        clk_en = 0; repeat (3) tick();
        n_cmp++; if (mem_rdata !== 32'h0000FFFF) begin $display("FAIL rd_hold got %h want 0000ffff", mem_rdata); n_bad++; end
        clk_en = 1; tick(); mem_re = 0;
        n_cmp++; if (mem_rdata !== 32'h00008000) begin $display("FAIL rd_active got %h want 00008000", mem_rdata); n_bad++; end
        wr_reg(OFF_PENDING, 32'h8000);
        n_cmp++; if (interrupts !== 16'h0) begin $display("FAIL force_clr got %h want 0000", interrupts); n_bad++; end
    endtask

    task automatic test_back_to_back();
        wr_reg(OFF_MASK, 32'h0A00);
        irq_src = 16'h0A00; tick(); irq_src = 0;
        repeat (LAT - 1) tick();
        n_cmp++; if (interrupts !== 16'h0A00 || irq_id !== 4'd9) begin $display("FAIL prio_two int=%h id=%0d want 0a00/9", interrupts, irq_id); n_bad++; end
        wr_reg(OFF_PENDING, 32'h0200);
        n_cmp++; if (interrupts !== 16'h0800 || irq_id !== 4'd11) begin $display("FAIL prio_next int=%h id=%0d want 0800/11", interrupts, irq_id); n_bad++; end
        wr_reg(OFF_PENDING, 32'h0800);
        n_cmp++; if (interrupts !== 16'h0 || irq_id !== 4'd0 || irq_any !== 1'b0) begin $display("FAIL prio_none int=%h id=%0d any=%b want 0/0/0", interrupts, irq_id, irq_any); n_bad++; end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr_reg(OFF_MASK, 32'hFFFF);
        irq_src = 16'hFFFF; repeat (LAT) tick();
        n_cmp++; if (interrupts !== 16'hFFFF || irq_id !== 4'd0) begin $display("FAIL pre_rst int=%h id=%0d want ffff/0", interrupts, irq_id); n_bad++; end
        rd_reg(OFF_ACTIVE, d);
        #2 rst = 1;
        #1 n_cmp++; if (interrupts !== 16'h0 || irq_any !== 1'b0 || irq_id !== 4'd0 || mem_rdata !== 32'h0) begin
            $display("FAIL async_rst int=%h any=%b id=%0d rdata=%h want all 0", interrupts, irq_any, irq_id, mem_rdata); n_bad++; end
        mem_addr = BASE + 18'(OFF_MASK); mem_wdata = 32'hFFFF; mem_we = 4'hF;
        tick(); tick(); mem_we = 0;
        rst = 0;
        repeat (5) tick();
        rd_reg(OFF_MASK, d);
        n_cmp++; if (d !== 32'h0) begin $display("FAIL rst_write got %h want 0", d); n_bad++; end
        wr_reg(OFF_MASK, 32'hFFFF);
        repeat (3) tick();
        rd_reg(OFF_PENDING, d);
        n_cmp++; if (interrupts !== 16'h0 || d !== 32'h0) begin $display("FAIL held_high int=%h pend=%h want 0/0", interrupts, d); n_bad++; end
        irq_src = 0; repeat (LAT + 1) tick();
        irq_src = 16'h0004; repeat (LAT) tick();
        n_cmp++; if (interrupts !== 16'h0004 || irq_id !== 4'd2) begin $display("FAIL fresh_edge int=%h id=%0d want 0004/2", interrupts, irq_id); n_bad++; end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_edge();
        test_edge_vs_w1c();
        test_level();
        test_clk_en();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
